conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 convolution engine with a programmable kernel, for pixel-rate image filtering.
//  Accepts one frame of pixels in raster order over a valid/ready stream and buffers two lines on chip.
//  Emits one filtered pixel per input pixel, in raster order: |conv| clamped to 2^BITW-1, border pixels forced to 0.
//  Sits between the pixel source (frame reader/DMA) and the pixel sink (frame writer/next filter).
// PARAMETERS
//  WIDTH   128  pixels per line (>=3)
//  HEIGHT  128  lines per frame (>=3)
//  BITW    8    unsigned pixel width
//  KW      8    signed kernel coefficient width
//  ACCW    20   signed accumulator width; must be >= BITW+KW+4
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input pixel valid
//  in_ready   out  1        block accepts in_pixel this cycle
//  in_pixel   in   BITW     input pixel, unsigned, raster order
//  out_valid  out  1        output pixel valid
//  out_ready  in   1        sink accepts out_pixel this cycle
//  out_pixel  out  BITW     filtered pixel
//  out_last   out  1        high with the final pixel (HEIGHT-1,WIDTH-1) of a frame
//  busy       out  1        frame in progress (state != IDLE)
//  k_wr_en    in   1        [CONV_KERNEL_LOAD_EN only] kernel coefficient write strobe
//  k_wr_idx   in   4        [CONV_KERNEL_LOAD_EN only] coefficient index 0..8, row-major k00..k22
//  k_wr_data  in   KW       [CONV_KERNEL_LOAD_EN only] signed coefficient
// BEHAVIOUR
//  Reset: out_valid=0, out_pixel=0, out_last=0, busy=0, in_ready=0 while rst_n=0; counters 0; state IDLE.
//   Line buffer contents are don't-care after reset and must not reach the output.
//  Accept: an input transfer occurs when in_valid && in_ready. The same rule applies to output transfers.
//  Stall: the pipeline holds when out_valid && !out_ready; in_ready=0 while stalled and in FLUSH.
//  FSM states:
//   IDLE: in_ready=1. The first accept moves the FSM to FILL.
//   FILL: runs until W+1 pixels have been accepted, then the FSM moves to RUN.
//   RUN: each accept of input index k+W+1 issues output index k. After input index W*H-1 is accepted, the FSM moves to FLUSH.
//   FLUSH: issues the remaining W+1 outputs with no input, one per non-stalled cycle. When out_last transfers, the FSM returns to IDLE.
//  Latency: 2 cycles from the issuing event to out_valid.
//   Stage 1 registers the 3x3 window and the 9 products.
//   Stage 2 registers sum, abs and clamp.
//  Throughput: 1 pixel/cycle when out_ready=1 and in_valid=1.
//  Arithmetic: each pixel is zero-extended to signed before multiplication. Sum in ACCW bits.
//   s<0 -> -s; s>2^BITW-1 -> 2^BITW-1.
//  Border: any output with r==0, r==H-1, c==0 or c==W-1 is 0. Its window is never evaluated, so no wrap-around data leaks.
//  Counters: row/col input and output counters wrap at W-1 -> 0 and H-1 -> 0. Back-to-back frames are allowed only via IDLE.
//  Reset mid-frame: all progress is discarded. The next accepted pixel is pixel (0,0) of a new frame.
// CONFIGURATION
//  Macro CONV_KERNEL_LOAD_EN:
//  Defined: the k_wr_* ports exist and the 9 coefficient registers reset to Sobel X (-1,0,1,-2,0,2,-1,0,1).
//   A write while busy=0 updates coefficient k_wr_idx on the next edge.
//   Writes while busy=1, or with idx>8, are ignored, so the kernel is constant within a frame.
//  Undefined: no k_wr_* ports; the kernel is hardwired to Sobel X.
// STRUCTURE
//  Package conv_pkg:
//   FSM state enum (IDLE, FILL, RUN, FLUSH)
//   SOBEL_X default coefficient constants
//   coefficient-index localparams
//   ACCW sizing check function
//  Sub-module conv_line_buffer: a 2-line BITW-wide circular buffer, depth WIDTH, with a shared write/read pointer and a shift-enable input.
//   Outputs are the two taps of the column above the incoming pixel.
//  Top level: FSM, counters, 3x3 window shift register, 2-stage MAC/clamp pipeline, handshake logic.
// TESTING
//  1. Constant image 100, W=H=8, out_ready=1 -> 64 outputs, all 0; out_last only on output 63; busy returns to 0.
//  2. Ramp pixel(r,c)=c, W=8 H=4 -> interior outputs = 8, borders = 0; first out_valid 2 cycles after input index 9 is accepted.
//  3. Vertical edge, W=H=128, cols<64=0, cols>=64=255 -> interior cols 63 and 64 = 255, all other outputs 0 (clamp of 1020).
//  4. Random in_valid and out_ready (50%) on the ramp image -> output sequence identical to test 2; no pixel lost or duplicated.
//  5. rst_n pulsed low at input index 20 of a frame, then a full frame -> out_valid=0 during reset; 2nd frame output matches golden exactly.
//  6. [CONV_KERNEL_LOAD_EN] load identity (k11=1, others 0) while idle; write attempt mid-frame ignored -> interior out = in, borders 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine.
// Holds the FSM state enum, the default Sobel X kernel and the accumulator sizing rule.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } conv_state_e;

  localparam int K_NUM = 9;
  localparam int K00 = 0;
  localparam int K01 = 1;
  localparam int K02 = 2;
  localparam int K10 = 3;
  localparam int K11 = 4;
  localparam int K12 = 5;
  localparam int K20 = 6;
  localparam int K21 = 7;
  localparam int K22 = 8;

  localparam int SOBEL_X [K_NUM] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

  // Nine products of a (BITW+1)-bit by KW-bit signed multiply need 4 guard bits.
  function automatic bit accw_ok(input int bitw, input int kw, input int accw);
    return accw >= bitw + kw + 4;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-line circular pixel buffer sharing one column pointer.
// tap1/tap2 are the pixels one and two lines above the column at ptr.
module conv_line_buffer #(
  parameter int WIDTH = 128,
  parameter int BITW  = 8,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            shift_en,
  input  logic [PW-1:0]   ptr,
  input  logic [BITW-1:0] din,
  output logic [BITW-1:0] tap1,
  output logic [BITW-1:0] tap2
);

  logic [BITW-1:0] line1 [WIDTH];
  logic [BITW-1:0] line2 [WIDTH];

  // Storage is not reset; stale lines only ever feed border outputs, which are forced to 0.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      line1[ptr] <= din;
      line2[ptr] <= line1[ptr];
    end
  end

  assign tap1 = line1[ptr];
  assign tap2 = line2[ptr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: |conv| clamped to 2^BITW-1, borders forced to 0.
// Optional macro CONV_KERNEL_LOAD_EN adds k_wr_* ports for a runtime-loadable kernel.
//   state | meaning
//   IDLE  | waiting for pixel (0,0)
//   FILL  | priming line buffer, no outputs issued
//   RUN   | each accept issues one output
//   FLUSH | draining last W+1 outputs, input blocked
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int BITW   = 8,
  parameter int KW     = 8,
  parameter int ACCW   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITW-1:0]      in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITW-1:0]      out_pixel,
  output logic                 out_last,
  output logic                 busy
`ifdef CONV_KERNEL_LOAD_EN
  ,
  input  logic                 k_wr_en,
  input  logic [3:0]           k_wr_idx,
  input  logic signed [KW-1:0] k_wr_data
`endif
);

  localparam int CW  = $clog2(WIDTH);
  localparam int RW  = $clog2(HEIGHT);
  localparam int PRW = BITW + 1 + KW;
  localparam logic [ACCW-1:0] ACC_MAX = ACCW'((1 << BITW) - 1);

  if (!accw_ok(BITW, KW, ACCW)) begin : g_accw_check
    $error("ACCW too small for BITW/KW");
  end

  conv_state_e            state;
  logic                   en_q, adv, accept, issue, done_issue;
  logic [CW-1:0]          in_col, out_col;
  logic [RW-1:0]          in_row, out_row;
  logic [BITW-1:0]        tap1, tap2;
  logic [BITW-1:0]        win     [K_NUM];
  logic [BITW-1:0]        win_nxt [K_NUM];
  logic signed [KW-1:0]   kern    [K_NUM];
  logic signed [PRW-1:0]  prod_q  [K_NUM];
  logic                   v1, border1, last1;
  logic signed [ACCW-1:0] sum;
  logic [ACCW-1:0]        mag;
  logic [BITW-1:0]        pix_c;
  logic                   in_at_last, out_at_last;

  assign adv         = !(out_valid && !out_ready);
  assign in_ready    = en_q && adv && (state != FLUSH);
  assign accept      = in_valid && in_ready;
  assign issue       = (accept && state == RUN) || (state == FLUSH && adv && !done_issue);
  assign busy        = (state != IDLE);
  assign in_at_last  = (in_row == RW'(HEIGHT - 1)) && (in_col == CW'(WIDTH - 1));
  assign out_at_last = (out_row == RW'(HEIGHT - 1)) && (out_col == CW'(WIDTH - 1));

  conv_line_buffer #(.WIDTH(WIDTH), .BITW(BITW), .PW(CW)) u_lbuf (
    .clk      (clk),
    .shift_en (accept),
    .ptr      (in_col),
    .din      (in_pixel),
    .tap1     (tap1),
    .tap2     (tap2)
  );

`ifdef CONV_KERNEL_LOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_NUM; i++) kern[i] <= KW'(SOBEL_X[i]);
    end else if (k_wr_en && !busy) begin
      for (int i = 0; i < K_NUM; i++)
        if (k_wr_idx == 4'(i)) kern[i] <= k_wr_data;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < K_NUM; i++) kern[i] = KW'(SOBEL_X[i]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      done_issue <= 1'b0;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      en_q <= 1'b1;
      case (state)
        IDLE:    if (accept) state <= FILL;
        FILL:    if (accept && in_row == RW'(1) && in_col == '0) state <= RUN;
        RUN:     if (accept && in_at_last) state <= FLUSH;
        FLUSH:   if (out_valid && out_ready && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (state == IDLE) done_issue <= 1'b0;
      else if (issue && out_at_last) done_issue <= 1'b1;
      if (accept) begin
        if (in_col == CW'(WIDTH - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(HEIGHT - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (issue) begin
        if (out_col == CW'(WIDTH - 1)) begin
          out_col <= '0;
          out_row <= (out_row == RW'(HEIGHT - 1)) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // Window row 0 is two lines above the incoming pixel; column 2 is the newest.
  always_comb begin
    for (int i = 0; i < K_NUM; i++) win_nxt[i] = win[i];
    if (accept) begin
      win_nxt[K00] = win[K01];  win_nxt[K01] = win[K02];  win_nxt[K02] = tap2;
      win_nxt[K10] = win[K11];  win_nxt[K11] = win[K12];  win_nxt[K12] = tap1;
      win_nxt[K20] = win[K21];  win_nxt[K21] = win[K22];  win_nxt[K22] = in_pixel;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < K_NUM; i++) sum = sum + ACCW'(prod_q[i]);
    mag   = sum[ACCW-1] ? -sum : sum;
    pix_c = (mag > ACC_MAX) ? '1 : mag[BITW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K_NUM; i++) begin
        win[i]    <= '0;
        prod_q[i] <= '0;
      end
      v1        <= 1'b0;
      border1   <= 1'b0;
      last1     <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else begin
      for (int i = 0; i < K_NUM; i++) win[i] <= win_nxt[i];
      if (adv) begin
        v1      <= issue;
        border1 <= (out_row == '0) || (out_row == RW'(HEIGHT - 1)) ||
                   (out_col == '0) || (out_col == CW'(WIDTH - 1));
        last1   <= out_at_last;
        for (int i = 0; i < K_NUM; i++)
          prod_q[i] <= PRW'($signed({1'b0, win_nxt[i]})) * PRW'(kern[i]);
        out_valid <= v1;
        out_last  <= v1 && last1;
        out_pixel <= (!v1 || border1) ? '0 : pix_c;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench: frames of structured and random images vs a plain-arithmetic 3x3 model.
module tb_conv3x3_stream;
  localparam int W = 10, H = 6, N = W * H;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_pixel = '0, out_pixel;
  logic       out_valid, out_ready = 1'b0, out_last, busy;
`ifdef CONV_KERNEL_LOAD_EN
  logic              k_wr_en = 1'b0;
  logic [3:0]        k_wr_idx = '0;
  logic signed [7:0] k_wr_data = '0;
`endif

  conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .BITW(8), .KW(8), .ACCW(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .busy(busy)
`ifdef CONV_KERNEL_LOAD_EN
    , .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx), .k_wr_data(k_wr_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int img [N];
  int kern [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int exp_q [$];
  int in_pct = 100, out_pct = 100;
  int acc_cyc = -1, first_v_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_pix(input int r, input int c);
    int s = 0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += kern[i * 3 + j] * img[(r - 1 + i) * W + (c - 1 + j)];
    if (s < 0) s = -s;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic load_expected();
    for (int k = 0; k < N; k++)
      exp_q.push_back(model_pix(k / W, k % W) | ((k == N - 1) ? 256 : 0));
  endtask

  initial forever begin
    @(negedge clk);
    out_ready = ($urandom_range(99) < out_pct);
  end

  always @(negedge clk) begin : mon
    int e;
    #2;
    if (rst_n && out_valid && first_v_cyc < 0) first_v_cyc = cyc;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_output", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_pixel", out_pixel, e & 255);
        check("out_last", out_last, e >> 8);
      end
    end
  end

  task automatic send_frame(input int abort_at);
    int idx = 0, guard = 0;
    while (idx < N && idx != abort_at) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) < in_pct);
      in_pixel = 8'(img[idx]);
      #1;
      if (in_valid && in_ready) begin
        if (idx == W + 1) acc_cyc = cyc;
        idx++;
      end
      if (++guard > 20000) begin
        check("input_timeout", idx, N);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #3;
    check({name, "_done"}, int'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic run_frame(input string name, input int ip, input int op);
    in_pct = ip;
    out_pct = op;
    load_expected();
    send_frame(-1);
    wait_done(name);
  endtask

  task automatic rand_img();
    for (int k = 0; k < N; k++) img[k] = $urandom_range(255);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_pixel", out_pixel, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) img[k] = 100;
    check("model_const", model_pix(2, 4), 0);
    run_frame("const", 100, 100);

    for (int k = 0; k < N; k++) img[k] = k % W;
    check("model_ramp", model_pix(2, 3), 8);
    first_v_cyc = -1;
    acc_cyc = -1;
    run_frame("ramp", 100, 100);
    check("latency", first_v_cyc - acc_cyc, 2);

    for (int k = 0; k < N; k++) img[k] = (k % W >= W / 2) ? 255 : 0;
    check("model_edge_l", model_pix(2, W / 2 - 1), 255);
    check("model_edge_r", model_pix(2, W / 2), 255);
    check("model_edge_flat", model_pix(2, W / 2 + 1), 0);
    run_frame("vedge", 100, 100);

    for (int k = 0; k < N; k++) img[k] = (W - 1 - k % W) * 25;
    check("model_negramp", model_pix(1, 1), 200);
    run_frame("negramp", 70, 80);

    for (int k = 0; k < N; k++) img[k] = k % W;
    run_frame("ramp_rand", 50, 50);

    for (int f = 0; f < 3; f++) begin
      rand_img();
      run_frame("random", 40 + 20 * f, 90 - 20 * f);
    end

    rand_img();
    in_pct = 100;
    out_pct = 100;
    load_expected();
    send_frame(20);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    rand_img();
    run_frame("after_rst", 60, 60);

`ifdef CONV_KERNEL_LOAD_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      k_wr_en = 1'b1;
      k_wr_idx = 4'(i);
      k_wr_data = (i == 4) ? 8'sd1 : 8'sd0;
      kern[i] = (i == 4) ? 1 : 0;
    end
    @(negedge clk);
    k_wr_idx = 4'd9;
    k_wr_data = 8'sd7;
    @(negedge clk);
    k_wr_en = 1'b0;
    rand_img();
    check("model_ident", model_pix(2, 3), img[2 * W + 3]);
    in_pct = 100;
    out_pct = 100;
    load_expected();
    fork
      send_frame(-1);
      begin
        repeat (15) @(negedge clk);
        k_wr_en = 1'b1;
        k_wr_idx = 4'd4;
        k_wr_data = 8'sd3;
        @(negedge clk);
        k_wr_en = 1'b0;
      end
    join
    wait_done("kernel_load");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
